// File: rtl/rs_pkg.sv
// Shared encodings for the reservation-station issue controller.
// FSM states, functional-unit classes and the class-to-strobe decode.
package rs_pkg;

  localparam int NUM_FU = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    FLUSH = 2'd3
  } rs_state_e;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    MUL = 2'd1,
    MEM = 2'd2,
    BR  = 2'd3
  } fu_class_e;

  function automatic logic [NUM_FU-1:0] class_onehot(input logic [1:0] cls);
    logic [NUM_FU-1:0] one;
    one = {{(NUM_FU-1){1'b0}}, 1'b1};
    return one << cls;
  endfunction

endpackage

// File: rtl/rs_issue_ctrl_if.sv
// Bundle between the RS head / FU issue ports and the issue controller.
// The slave modport is the controller's view; master is the RS/FU side.
interface rs_issue_ctrl_if #(
  parameter int TAG_W = 4
);

  logic                        RSBufEmpty;
  logic                        RSHeadFlagA;
  logic                        RSHeadFlagB;
  logic [1:0]                  RSHeadOpClass;
  logic [rs_pkg::NUM_FU-1:0]   FUReady;
  logic                        Branch;
  logic                        Stall;

  logic                        RSRdEn;
  logic [rs_pkg::NUM_FU-1:0]   IssueValid;
  logic [TAG_W-1:0]            IssueTag;
  logic                        Timeout;
  logic [15:0]                 StallCnt;
  logic [1:0]                  State;

  modport slave (
    input  RSBufEmpty, RSHeadFlagA, RSHeadFlagB, RSHeadOpClass,
    input  FUReady, Branch, Stall,
    output RSRdEn, IssueValid, IssueTag, Timeout, StallCnt, State
  );

  modport master (
    output RSBufEmpty, RSHeadFlagA, RSHeadFlagB, RSHeadOpClass,
    output FUReady, Branch, Stall,
    input  RSRdEn, IssueValid, IssueTag, Timeout, StallCnt, State
  );

endinterface

// File: rtl/rs_issue_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rs_issue_ctrl.sv
// Issue scheduler: pops the RS head into exactly one FU class when its operands
// and target FU are ready, with branch flush, global stall and wait bookkeeping.
module rs_issue_ctrl
  import rs_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int TIMEOUT      = 255,
  parameter int TAG_W        = 4
) (
  input  logic           CLK,
  input  logic           Reset_n,
  rs_issue_ctrl_if.slave bus
);

  rs_state_e         state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rd_en_q, rd_en_d;
  logic [NUM_FU-1:0] issue_q, issue_d;

  logic [NUM_FU-1:0] cls_hit;
  logic              go;
  logic              wait_inc;
  logic              wait_clr;
  logic [7:0]        wait_cnt;
  logic [15:0]       stall_cnt;

  // Only the FU matching the head's class may gate the issue decision.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_cls_hit
    assign cls_hit[gi] = bus.FUReady[gi] && (bus.RSHeadOpClass == 2'(gi));
  end

  assign go = !bus.RSBufEmpty && bus.RSHeadFlagA && bus.RSHeadFlagB && (|cls_hit);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tag_d       = tag_q;
    rd_en_d     = 1'b0;
    issue_d     = '0;
    wait_inc    = 1'b0;
    wait_clr    = 1'b0;

    if (bus.Branch) begin
      state_d     = FLUSH;
      flush_cnt_d = 4'(FLUSH_CYCLES - 1);
      wait_clr    = 1'b1;
      // An issue already presented in ISSUE still consumes its tag.
      if (state_q == ISSUE) begin
        tag_d = tag_q + 1'b1;
      end
    end else if (bus.Stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            state_d  = IDLE;
            wait_clr = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        IDLE, WAIT: begin
          if (go) begin
            state_d  = ISSUE;
            rd_en_d  = 1'b1;
            issue_d  = class_onehot(bus.RSHeadOpClass);
            wait_clr = 1'b1;
          end else if (!bus.RSBufEmpty) begin
            state_d  = WAIT;
            wait_inc = 1'b1;
          end else begin
            state_d  = IDLE;
            wait_clr = 1'b1;
          end
        end
        ISSUE: begin
          // The pop takes a cycle to land, so the head is not re-checked here.
          state_d  = IDLE;
          tag_d    = tag_q + 1'b1;
          wait_clr = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      tag_q       <= '0;
      rd_en_q     <= 1'b0;
      issue_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tag_q       <= tag_d;
      rd_en_q     <= rd_en_d;
      issue_q     <= issue_d;
    end
  end

  sat_counter #(.WIDTH(8)) u_wait_cnt (
    .clk   (CLK),
    .rst_n (Reset_n),
    .inc_i (wait_inc),
    .clr_i (wait_clr),
    .cnt_o (wait_cnt)
  );

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (Reset_n),
    .inc_i (wait_inc),
    .clr_i (1'b0),
    .cnt_o (stall_cnt)
  );

  assign bus.RSRdEn     = rd_en_q;
  assign bus.IssueValid = issue_q;
  assign bus.IssueTag   = tag_q;
  assign bus.Timeout    = (wait_cnt >= 8'(TIMEOUT));
  assign bus.StallCnt   = stall_cnt;
  assign bus.State      = state_q;

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Directed bench for rs_issue_ctrl: hand-computed expectations per cycle,
// outputs sampled 1 ns after the rising edge.
module tb_rs_issue_ctrl;
  import rs_pkg::*;

  logic clk;
  logic rst_n;
  int   n_run  = 0;
  int   n_fail = 0;

  rs_issue_ctrl_if #(.TAG_W(4)) bus ();

  rs_issue_ctrl #(
    .FLUSH_CYCLES (3),
    .TIMEOUT      (255),
    .TAG_W        (4)
  ) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic empty, input logic fa, input logic fb,
                          input logic [1:0] cls, input logic [3:0] rdy);
    bus.RSBufEmpty    = empty;
    bus.RSHeadFlagA   = fa;
    bus.RSHeadFlagB   = fb;
    bus.RSHeadOpClass = cls;
    bus.FUReady       = rdy;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic rd,
                            input logic [3:0] iv, input logic [3:0] tg);
    check({tag, "/state"}, 32'(bus.State), 32'(st));
    check({tag, "/rden"},  32'(bus.RSRdEn), 32'(rd));
    check({tag, "/iv"},    32'(bus.IssueValid), 32'(iv));
    check({tag, "/tag"},   32'(bus.IssueTag), 32'(tg));
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.Branch = 1'b0;
    bus.Stall  = 1'b0;
    set_head(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step();
    step();

    // Reset state
    expect_out("reset", IDLE, 1'b0, 4'b0000, 4'd0);
    check("reset/timeout", 32'(bus.Timeout), 32'd0);
    check("reset/stallcnt", 32'(bus.StallCnt), 32'd0);
    rst_n = 1'b1;

    // Empty RS with stale-high flags must never issue
    set_head(1'b1, 1'b1, 1'b1, 2'd1, 4'b1111);
    step();
    expect_out("empty1", IDLE, 1'b0, 4'b0000, 4'd0);
    step();
    expect_out("empty2", IDLE, 1'b0, 4'b0000, 4'd0);
    $display("[TB] txn empty-head: no issue");

    // First issue: class MUL
    set_head(1'b0, 1'b1, 1'b1, 2'd1, 4'b0010);
    step();
    expect_out("mul_issue", ISSUE, 1'b1, 4'b0010, 4'd0);
    set_head(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step();
    expect_out("mul_done", IDLE, 1'b0, 4'b0000, 4'd1);
    $display("[TB] txn issue MUL tag 0");

    // Operand B late by 10 cycles
    set_head(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("wait/state", 32'(bus.State), 32'(WAIT));
      check("wait/stallcnt", 32'(bus.StallCnt), 32'(i));
    end
    check("wait/waitcnt", 32'(dut.wait_cnt), 32'd10);
    bus.RSHeadFlagB = 1'b1;
    step();
    expect_out("mem_issue", ISSUE, 1'b1, 4'b0100, 4'd1);
    check("mem_issue/waitcnt", 32'(dut.wait_cnt), 32'd0);
    check("mem_issue/stallcnt", 32'(bus.StallCnt), 32'd10);
    set_head(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step();
    expect_out("mem_done", IDLE, 1'b0, 4'b0000, 4'd2);
    $display("[TB] txn issue MEM tag 1 after 10 wait cycles");

    // Branch coincident with go: flush 3 cycles, then issue
    set_head(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001);
    bus.Branch = 1'b1;
    step();
    expect_out("br_f1", FLUSH, 1'b0, 4'b0000, 4'd2);
    bus.Branch = 1'b0;
    step();
    expect_out("br_f2", FLUSH, 1'b0, 4'b0000, 4'd2);
    step();
    expect_out("br_f3", FLUSH, 1'b0, 4'b0000, 4'd2);
    step();
    expect_out("br_idle", IDLE, 1'b0, 4'b0000, 4'd2);
    step();
    expect_out("br_issue", ISSUE, 1'b1, 4'b0001, 4'd2);
    set_head(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step();
    expect_out("br_done", IDLE, 1'b0, 4'b0000, 4'd3);
    $display("[TB] txn branch flush then issue ALU tag 2");

    // Second branch mid-flush reloads the counter
    bus.Branch = 1'b1;
    step();
    check("rebr/s1", 32'(bus.State), 32'(FLUSH));
    bus.Branch = 1'b0;
    step();
    check("rebr/s2", 32'(bus.State), 32'(FLUSH));
    bus.Branch = 1'b1;
    step();
    check("rebr/reload", 32'(bus.State), 32'(FLUSH));
    bus.Branch = 1'b0;
    step();
    check("rebr/r2", 32'(bus.State), 32'(FLUSH));
    step();
    check("rebr/r3", 32'(bus.State), 32'(FLUSH));
    step();
    check("rebr/idle", 32'(bus.State), 32'(IDLE));
    $display("[TB] txn re-branch extends flush");

    // Blocked BR head: Timeout at the 255th WAIT cycle
    set_head(1'b0, 1'b1, 1'b1, 2'd3, 4'b0000);
    for (int i = 1; i <= 300; i++) begin
      step();
      check("blk/timeout", 32'(bus.Timeout), (i >= 255) ? 32'd1 : 32'd0);
    end
    check("blk/state", 32'(bus.State), 32'(WAIT));
    check("blk/stallcnt", 32'(bus.StallCnt), 32'd310);
    bus.FUReady = 4'b1000;
    step();
    expect_out("br_cls_issue", ISSUE, 1'b1, 4'b1000, 4'd3);
    check("br_cls_issue/timeout", 32'(bus.Timeout), 32'd0);
    set_head(1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    step();
    expect_out("br_cls_done", IDLE, 1'b0, 4'b0000, 4'd4);
    $display("[TB] txn blocked 300 cycles then issue BR tag 3");

    // Fresh reset, then 17 back-to-back issues with a 5-cycle stall
    rst_n = 1'b0;
    #1;
    check("rst2/tag", 32'(bus.IssueTag), 32'd0);
    check("rst2/stallcnt", 32'(bus.StallCnt), 32'd0);
    step();
    step();
    set_head(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001);
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      expect_out("b2b_issue", ISSUE, 1'b1, 4'b0001, 4'(k));
      if (k == 8) begin
        bus.Stall = 1'b1;
        for (int s = 0; s < 5; s++) begin
          step();
          expect_out("b2b_stall", ISSUE, 1'b0, 4'b0000, 4'd8);
        end
        bus.Stall = 1'b0;
      end
      step();
      expect_out("b2b_idle", IDLE, 1'b0, 4'b0000, 4'(k + 1));
      $display("[TB] txn b2b issue %0d tag %0d", k, k % 16);
    end
    check("b2b/stallcnt", 32'(bus.StallCnt), 32'd0);

    // Asynchronous reset while in ISSUE
    step();
    expect_out("arst_pre", ISSUE, 1'b1, 4'b0001, 4'd1);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("arst", IDLE, 1'b0, 4'b0000, 4'd0);
    check("arst/timeout", 32'(bus.Timeout), 32'd0);
    check("arst/stallcnt", 32'(bus.StallCnt), 32'd0);
    rst_n = 1'b1;
    $display("[TB] txn async reset during ISSUE");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
